// File: rtl/pipelined_exec_datapath.sv
// Two-stage execute datapath: issue/execute (operand read, optional
// immediate, ALU) feeding a write-back register that owns the single
// register-file write port. Valid/ready on both ends, x0 hardwired to zero,
// write-back-to-issue forwarding, and a combinational debug read port.
module pipelined_exec_datapath #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int RAW   = 5
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [RAW-1:0]  rs1,
  input  logic [RAW-1:0]  rs2,
  input  logic [RAW-1:0]  rd,
  input  logic [3:0]      alu_control,
  input  logic            use_imm,
  input  logic [XLEN-1:0] imm,
  input  logic            regwrite,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero_flag,
  input  logic [RAW-1:0]  dbg_addr,
  output logic [XLEN-1:0] dbg_data
);

  localparam int SHW = $clog2(XLEN);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SLTU = 4'b1000;
  localparam logic [3:0] OP_SRA  = 4'b1001;

  // Write-back stage contents: everything needed to retire one result.
  typedef struct packed {
    logic            vld;
    logic [RAW-1:0]  rd;
    logic            we;
    logic            zero;
    logic [XLEN-1:0] res;
  } wb_t;

  wb_t             wb_q, wb_d;
  logic [XLEN-1:0] rf_q [NREGS];

  logic            issue_fire, wb_fire, rf_we;
  logic            wb_fwd_ok, fwd_a, fwd_b;
  logic [XLEN-1:0] rf_a, rf_b, op_a, op_b, alu_y;
  logic [SHW-1:0]  shamt;

  // A held result only blocks issue when the consumer is not taking it now.
  assign in_ready   = ~wb_q.vld | out_ready;
  assign issue_fire = in_valid & in_ready;
  assign wb_fire    = wb_q.vld & out_ready;
  // x0 writes are dropped here so rf_q[0] stays at its reset value of 0.
  assign rf_we      = wb_fire & wb_q.we & (wb_q.rd != '0);

  assign rf_a = (rs1 == '0) ? '0 : rf_q[rs1];
  assign rf_b = (rs2 == '0) ? '0 : rf_q[rs2];

  // The held result is the newest value of wb_q.rd whether or not it is
  // retiring this cycle, so forwarding does not depend on out_ready.
  assign wb_fwd_ok = wb_q.vld & wb_q.we & (wb_q.rd != '0);
  assign fwd_a     = wb_fwd_ok & (wb_q.rd == rs1);
  assign fwd_b     = wb_fwd_ok & (wb_q.rd == rs2) & ~use_imm;

  assign op_a  = fwd_a   ? wb_q.res : rf_a;
  assign op_b  = use_imm ? imm : (fwd_b ? wb_q.res : rf_b);
  assign shamt = op_b[SHW-1:0];

  // ALU: unknown opcodes produce 0.
  always_comb begin
    alu_y = '0;
    case (alu_control)
      OP_AND:  alu_y = op_a & op_b;
      OP_OR:   alu_y = op_a | op_b;
      OP_ADD:  alu_y = op_a + op_b;
      OP_SUB:  alu_y = op_a - op_b;
      OP_XOR:  alu_y = op_a ^ op_b;
      OP_SLL:  alu_y = op_a << shamt;
      OP_SRL:  alu_y = op_a >> shamt;
      OP_SRA:  alu_y = $signed(op_a) >>> shamt;
      OP_SLT:  alu_y = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      OP_SLTU: alu_y = {{(XLEN-1){1'b0}}, (op_a < op_b)};
      default: alu_y = '0;
    endcase
  end

  // Write-back next state: a new issue always wins; otherwise a retiring
  // result empties the stage. Payload is kept stable while held.
  always_comb begin
    wb_d = wb_q;
    if (issue_fire) begin
      wb_d.vld  = 1'b1;
      wb_d.rd   = rd;
      wb_d.we   = regwrite;
      wb_d.res  = alu_y;
      wb_d.zero = (alu_y == '0);
    end else if (wb_fire) begin
      wb_d.vld = 1'b0;
    end
  end

  // Write-back register; reset discards any held result.
  always_ff @(posedge clock) begin
    if (reset) wb_q <= '0;
    else       wb_q <= wb_d;
  end

  // Register file: single write port driven by the retiring result.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
    end else if (rf_we) begin
      rf_q[wb_q.rd] <= wb_q.res;
    end
  end

  assign out_valid = wb_q.vld;
  assign result    = wb_q.res;
  assign zero_flag = wb_q.zero;
  // Debug view is architectural state only; the held result is not forwarded.
  assign dbg_data  = (dbg_addr == '0) ? '0 : rf_q[dbg_addr];

endmodule

// File: tb/tb_pipelined_exec_datapath.sv
// Bench for pipelined_exec_datapath: directed vector table, a reset-while-
// holding sequence, and randomized traffic against a reference model that
// tracks program-order register values plus a queue of un-retired writes.
module tb_pipelined_exec_datapath;
  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int RAW   = 5;

  logic            clock = 1'b0;
  logic            reset;
  logic            in_valid, in_ready, use_imm, regwrite;
  logic            out_valid, out_ready, zero_flag;
  logic [RAW-1:0]  rs1, rs2, rd, dbg_addr;
  logic [3:0]      alu_control;
  logic [XLEN-1:0] imm, result, dbg_data;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  pipelined_exec_datapath #(.XLEN(XLEN), .NREGS(NREGS), .RAW(RAW)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .rs1(rs1), .rs2(rs2), .rd(rd), .alu_control(alu_control),
    .use_imm(use_imm), .imm(imm), .regwrite(regwrite),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero_flag(zero_flag),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  // ---------------- reference model ----------------
  typedef struct { logic [RAW-1:0] rd; logic we; logic [XLEN-1:0] val; } pend_t;
  logic [XLEN-1:0] arch [NREGS];  // what the register file should hold
  logic [XLEN-1:0] view [NREGS];  // value each register has in program order
  pend_t           pendq [$];     // results issued but not yet retired

  function automatic logic [XLEN-1:0] ref_alu(input logic [3:0] op,
                                              input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b);
    int unsigned sh;
    longint sa, sb;
    sh = b[4:0];
    sa = $signed(a);
    sb = $signed(b);
    case (op)
      4'd0: return a & b;
      4'd1: return a | b;
      4'd2: return a + b;
      4'd6: return a - b;
      4'd3: return a ^ b;
      4'd4: return a << sh;
      4'd5: return a >> sh;
      4'd9: return a[XLEN-1] ? ~((~a) >> sh) : (a >> sh);
      4'd7: return (sa < sb) ? 1 : 0;
      4'd8: return (a < b) ? 1 : 0;
      default: return 0;
    endcase
  endfunction

  task automatic check(input string name, input logic [XLEN-1:0] act,
                       input logic [XLEN-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_check();
    check("m_out_valid", out_valid, (pendq.size() != 0));
    check("m_in_ready", in_ready, (pendq.size() == 0 || out_ready));
    check("m_dbg_data", dbg_data, arch[dbg_addr]);
    if (pendq.size() != 0) begin
      check("m_result", result, pendq[0].val);
      check("m_zero_flag", zero_flag, (pendq[0].val == 0));
    end
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_edge();
    bit ir, wbf, isf;
    logic [XLEN-1:0] a, b, r;
    pend_t p, w;
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin arch[i] = '0; view[i] = '0; end
      pendq.delete();
    end else begin
      ir  = (pendq.size() == 0) || out_ready;
      wbf = (pendq.size() != 0) && out_ready;
      isf = in_valid && ir;
      a = view[rs1];
      b = use_imm ? imm : view[rs2];
      if (wbf) begin
        w = pendq.pop_front();
        if (w.we && w.rd != 0) arch[w.rd] = w.val;
      end
      if (isf) begin
        r = ref_alu(alu_control, a, b);
        p.rd = rd; p.we = regwrite; p.val = r;
        pendq.push_back(p);
        if (regwrite && rd != 0) view[rd] = r;
      end
    end
  endtask

  // Called #1 after the negedge where inputs were applied.
  task automatic tick();
    model_check();
    model_edge();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic drive(input logic v, input int s1, input int s2, input int d,
                       input int op, input logic ui, input logic [XLEN-1:0] im,
                       input logic rw, input logic ordy, input int dbg);
    in_valid = v; rs1 = RAW'(s1); rs2 = RAW'(s2); rd = RAW'(d);
    alu_control = 4'(op); use_imm = ui; imm = im; regwrite = rw;
    out_ready = ordy; dbg_addr = RAW'(dbg);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic v; int s1, s2, d, op; logic ui; logic [XLEN-1:0] im;
    logic rw, ordy; int dbg;
    logic eov, eir, cres; logic [XLEN-1:0] eres; logic ezf; logic [XLEN-1:0] edbg;
  } vec_t;

  function automatic vec_t mk(input int v, input int s1, input int s2, input int d,
                              input int op, input int ui, input logic [XLEN-1:0] im,
                              input int rw, input int ordy, input int dbg,
                              input int eov, input int eir, input int cres,
                              input logic [XLEN-1:0] eres, input int ezf,
                              input logic [XLEN-1:0] edbg);
    vec_t t;
    t.v = 1'(v); t.s1 = s1; t.s2 = s2; t.d = d; t.op = op; t.ui = 1'(ui);
    t.im = im; t.rw = 1'(rw); t.ordy = 1'(ordy); t.dbg = dbg;
    t.eov = 1'(eov); t.eir = 1'(eir); t.cres = 1'(cres); t.eres = eres;
    t.ezf = 1'(ezf); t.edbg = edbg;
    return t;
  endfunction

  vec_t tbl [21];

  initial begin
    // Expected outputs in each row are the values seen while that row's
    // inputs are applied, before the following clock edge.
    //            v s1 s2 d op ui imm           rw or dbg   ov ir cr res           zf dbg
    tbl[0]  = mk(1, 0, 0, 1, 2, 1, 5,            1, 1, 1,   0, 1, 0, 0,            0, 0);
    tbl[1]  = mk(0, 0, 0, 0, 0, 0, 0,            0, 1, 1,   1, 1, 1, 5,            0, 0);
    tbl[2]  = mk(1, 0, 0, 1, 2, 1, 7,            1, 1, 1,   0, 1, 0, 0,            0, 5);
    tbl[3]  = mk(1, 1, 1, 2, 6, 0, 0,            1, 1, 1,   1, 1, 1, 7,            0, 5);
    tbl[4]  = mk(0, 0, 0, 0, 0, 0, 0,            0, 1, 2,   1, 1, 1, 0,            1, 0);
    tbl[5]  = mk(1, 0, 0, 3, 2, 1, 9,            1, 1, 1,   0, 1, 0, 0,            0, 7);
    tbl[6]  = mk(0, 0, 0, 0, 0, 0, 0,            0, 0, 3,   1, 0, 1, 9,            0, 0);
    tbl[7]  = mk(1, 0, 0, 4, 2, 1, 1,            1, 0, 3,   1, 0, 1, 9,            0, 0);
    tbl[8]  = mk(0, 0, 0, 0, 0, 0, 0,            0, 0, 3,   1, 0, 1, 9,            0, 0);
    tbl[9]  = mk(0, 0, 0, 0, 0, 0, 0,            0, 1, 3,   1, 1, 1, 9,            0, 0);
    tbl[10] = mk(0, 0, 0, 0, 0, 0, 0,            0, 1, 3,   0, 1, 0, 0,            0, 9);
    tbl[11] = mk(1, 0, 0, 0, 2, 1, 32'hFFFF_FFFF, 1, 1, 0,  0, 1, 0, 0,            0, 0);
    tbl[12] = mk(1, 0, 0, 6, 2, 0, 0,            1, 1, 0,   1, 1, 1, 32'hFFFF_FFFF, 0, 0);
    tbl[13] = mk(1, 0, 0, 4, 2, 1, 32'h8000_0000, 1, 1, 0,  1, 1, 1, 0,            1, 0);
    tbl[14] = mk(1, 4, 0, 7, 9, 1, 4,            1, 1, 4,   1, 1, 1, 32'h8000_0000, 0, 0);
    tbl[15] = mk(1, 4, 0, 7, 5, 1, 4,            1, 1, 4,   1, 1, 1, 32'hF800_0000, 0, 32'h8000_0000);
    tbl[16] = mk(1, 4, 0, 8, 7, 0, 0,            1, 1, 4,   1, 1, 1, 32'h0800_0000, 0, 32'h8000_0000);
    tbl[17] = mk(1, 4, 0, 8, 8, 0, 0,            1, 1, 4,   1, 1, 1, 1,            0, 32'h8000_0000);
    tbl[18] = mk(1, 4, 0, 9, 15, 1, 3,           1, 1, 7,   1, 1, 1, 0,            1, 32'h0800_0000);
    tbl[19] = mk(0, 0, 0, 0, 0, 0, 0,            0, 1, 9,   1, 1, 1, 0,            1, 0);
    tbl[20] = mk(0, 0, 0, 0, 0, 0, 0,            0, 1, 9,   0, 1, 0, 0,            0, 0);
  end

  // ---------------- test sequence ----------------
  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    @(negedge clock);
    for (int i = 0; i < 2; i++) begin #1; tick(); end
    reset = 1'b0;

    // Reset state
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_result", result, 0);
    check("rst_zero_flag", zero_flag, 0);
    tick();
    for (int a = 1; a < NREGS; a += 10) begin
      dbg_addr = RAW'(a);
      #1;
      check("rst_dbg", dbg_data, 0);
      tick();
    end

    // Directed table
    for (int i = 0; i < 21; i++) begin
      drive(tbl[i].v, tbl[i].s1, tbl[i].s2, tbl[i].d, tbl[i].op, tbl[i].ui,
            tbl[i].im, tbl[i].rw, tbl[i].ordy, tbl[i].dbg);
      #1;
      check($sformatf("vec%0d_out_valid", i), out_valid, tbl[i].eov);
      check($sformatf("vec%0d_in_ready", i), in_ready, tbl[i].eir);
      check($sformatf("vec%0d_dbg", i), dbg_data, tbl[i].edbg);
      if (tbl[i].cres) begin
        check($sformatf("vec%0d_result", i), result, tbl[i].eres);
        check($sformatf("vec%0d_zero", i), zero_flag, tbl[i].ezf);
      end
      tick();
    end

    // Reset while a result is held: it must be discarded, never written.
    drive(1, 0, 0, 5, 2, 1, 3, 1, 1, 5);
    #1; tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 5);
    #1;
    check("hold_out_valid", out_valid, 1);
    check("hold_result", result, 3);
    check("hold_dbg_x5", dbg_data, 0);
    tick();
    reset = 1'b1; out_ready = 1'b1;
    #1; tick();
    reset = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_result", result, 0);
    check("mid_rst_dbg_x5", dbg_data, 0);
    tick();
    dbg_addr = RAW'(1);
    #1;
    check("mid_rst_dbg_x1", dbg_data, 0);
    tick();
    dbg_addr = RAW'(5);
    #1;
    check("mid_rst_dbg_x5_late", dbg_data, 0);
    tick();

    // Randomized traffic against the model
    for (int n = 0; n < 800; n++) begin
      logic [XLEN-1:0] im;
      case ($urandom_range(0, 3))
        0:       im = $urandom();
        1:       im = 32'h8000_0000;
        default: im = $urandom_range(0, 40);
      endcase
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
            $urandom_range(0, 7), $urandom_range(0, 15), $urandom_range(0, 1) != 0,
            im, $urandom_range(0, 4) != 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 7));
      reset = ($urandom_range(0, 99) == 0);
      #1; tick();
    end
    reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
